// File: rtl/vga_sprite_timing_if.sv
// vga_sprite_timing_if: sprite position inputs and raster, sprite and sync outputs of vga_sprite_timing
interface vga_sprite_timing_if;
   logic [9:0] i_sprite_x;
   logic [9:0] i_sprite_y;
   logic       i_pos_valid;
   logic [9:0] o_sx;
   logic [9:0] o_sy;
   logic [5:0] o_lx;
   logic [5:0] o_ly;
   logic       o_in_sprite;
   logic       o_frame;
   logic       o_hsync_d;
   logic       o_vsync_d;
   logic       o_de_d;
   logic       o_in_sprite_d;
   modport master (
      output i_sprite_x, i_sprite_y, i_pos_valid,
      input  o_sx, o_sy, o_lx, o_ly, o_in_sprite, o_frame,
             o_hsync_d, o_vsync_d, o_de_d, o_in_sprite_d
   );
   modport slave (
      input  i_sprite_x, i_sprite_y, i_pos_valid,
      output o_sx, o_sy, o_lx, o_ly, o_in_sprite, o_frame,
             o_hsync_d, o_vsync_d, o_de_d, o_in_sprite_d
   );
endinterface

// File: rtl/vga_sprite_timing.sv
// vga_sprite_timing: VGA raster counters, sync/enable generation and sprite-local coordinates with aligned delay line
module vga_sprite_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SPR_SIZE = 64,
   parameter int PIPE_DLY = 4
) (
   input logic                i_clk_25,
   input logic                i_rst,
   vga_sprite_timing_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] HA       = 11'(H_ACTIVE);
   localparam logic [10:0] HS_ON    = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VA       = 11'(V_ACTIVE);
   localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] SPR      = 11'(SPR_SIZE);
   localparam logic [10:0] SPR_MASK = 11'(SPR_SIZE - 1);
   localparam logic [3:0]  IDLE     = 4'b1100;

   logic [9:0]  sx, sy, shadow_x, shadow_y, pos_x, pos_y;
   logic        h_last, v_last;
   logic [10:0] x, y, px, py, dx, dy;
   logic        de, hsync, vsync, in_sprite;
   logic [3:0]  taps;

   // 11-bit compares keep px+SPR_SIZE from wrapping, so sprites clip at the right edge
   always_comb begin
      h_last    = sx == H_LAST;
      v_last    = sy == V_LAST;
      x         = {1'b0, sx};
      y         = {1'b0, sy};
      px        = {1'b0, pos_x};
      py        = {1'b0, pos_y};
      dx        = x - px;
      dy        = y - py;
      de        = x < HA && y < VA;
      hsync     = !(x >= HS_ON && x < HS_OFF);
      vsync     = !(y >= VS_ON && y < VS_OFF);
      in_sprite = de && x >= px && x < px + SPR && y >= py && y < py + SPR;
   end

   // active position only changes on the last pixel so a frame never shows a torn sprite
   always_ff @(posedge i_clk_25) begin
      if (i_rst) begin
         sx       <= '0;
         sy       <= '0;
         shadow_x <= '0;
         shadow_y <= '0;
         pos_x    <= '0;
         pos_y    <= '0;
      end else begin
         sx <= h_last ? '0 : sx + 10'd1;
         if (h_last) sy <= v_last ? '0 : sy + 10'd1;
         if (bus.i_pos_valid) begin
            shadow_x <= bus.i_sprite_x;
            shadow_y <= bus.i_sprite_y;
         end
         if (h_last && v_last) begin
            pos_x <= shadow_x;
            pos_y <= shadow_y;
         end
      end
   end

   generate
      if (PIPE_DLY == 0) begin : g_bypass
         assign taps = {hsync, vsync, de, in_sprite};
      end else begin : g_pipe
         logic [3:0] stage [PIPE_DLY];
         always_ff @(posedge i_clk_25) begin
            if (i_rst) begin
               for (int i = 0; i < PIPE_DLY; i++) stage[i] <= IDLE;
            end else begin
               stage[0] <= {hsync, vsync, de, in_sprite};
               for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
            end
         end
         assign taps = stage[PIPE_DLY-1];
      end
   endgenerate

   assign bus.o_sx        = sx;
   assign bus.o_sy        = sy;
   assign bus.o_lx        = in_sprite ? 6'(dx & SPR_MASK) : '0;
   assign bus.o_ly        = in_sprite ? 6'(dy & SPR_MASK) : '0;
   assign bus.o_in_sprite = in_sprite;
   assign bus.o_frame     = sx == '0 && y == VA;
   assign {bus.o_hsync_d, bus.o_vsync_d, bus.o_de_d, bus.o_in_sprite_d} = taps;
endmodule
